// File: rtl/adc_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : adc_sample_fifo
//  Purpose  : Capture FIFO for decimated VCO-ADC samples. Accepts 32-bit
//             samples on the decimator valid strobe while a capture session
//             is running, buffers them in a 16-deep synchronous FIFO and
//             presents them on a registered read port with level, threshold
//             interrupt, sticky overflow and session status.
//  Revision : 1.0  initial release
// ============================================================================
module adc_sample_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,            // synchronous, active low
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid_in,
   input  logic                  start_in,
   input  logic                  stop_in,
   input  logic                  oneshot_in,
   input  logic [15:0]           count_in,
   input  logic                  clear_in,
   input  logic                  rd_en_in,
   output logic [DATA_WIDTH-1:0] rd_data_out,
   output logic                  rd_valid_out,
   input  logic [ADDR_WIDTH:0]   threshold_in,
   output logic [ADDR_WIDTH:0]   level_out,
   output logic                  empty_out,
   output logic                  full_out,
   output logic                  overflow_out,
   output logic                  done_out,
   output logic                  busy_out,
   output logic                  irq_out
);

   localparam int                DEPTH      = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LEVEL_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [15:0]       CNT_MAX    = 16'hFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]     level_q, level_d;
   logic [15:0]             cap_cnt_q, cap_cnt_d;
   logic [15:0]             target_q, target_d;
   logic                    oneshot_q, oneshot_d;
   logic                    overflow_q, overflow_d;
   logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                    rd_valid_q, rd_valid_d;
   logic                    irq_q, irq_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   // ------------------------------------------------------------------
   // Combinational qualifiers
   // ------------------------------------------------------------------
   logic        fifo_empty;
   logic        fifo_full;
   logic        wr_offered;
   logic        rd_accept;
   logic        wr_accept;
   logic        session_start;
   logic        final_write;
   logic [15:0] cap_cnt_inc;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == FULL_LEVEL);

   // clear_in discards both the read and the write of its cycle.
   assign rd_accept  = rd_en_in && !fifo_empty && !clear_in;
   assign wr_offered = (state_q == ST_RUN) && data_valid_in && !clear_in;
   // A read in the same cycle frees the slot a full FIFO needs.
   assign wr_accept  = wr_offered && (!fifo_full || rd_accept);

   // stop_in wins over start_in; in DONE, clear_in wins over start_in.
   assign session_start = start_in && !stop_in &&
                          ((state_q == ST_IDLE) ||
                           ((state_q == ST_DONE) && !clear_in));

   // Saturating increment of the captured-sample count.
   assign cap_cnt_inc = (cap_cnt_q == CNT_MAX) ? cap_cnt_q : (cap_cnt_q + 16'd1);

   // One-shot completes on the edge that stores the last requested sample.
   assign final_write = oneshot_q && wr_accept && (cap_cnt_inc == target_q);

   // Session FSM next-state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (session_start) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (stop_in) begin
               state_d = ST_IDLE;
            end else if (final_write) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (clear_in) begin
               state_d = ST_IDLE;
            end else if (session_start) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Session parameters and captured-sample count
   always_comb begin
      oneshot_d = oneshot_q;
      target_d  = target_q;
      cap_cnt_d = cap_cnt_q;
      if (session_start) begin
         oneshot_d = oneshot_in;
         // A programmed count of zero behaves as a single sample.
         target_d  = (count_in == 16'd0) ? 16'd1 : count_in;
      end
      if (clear_in || session_start) begin
         cap_cnt_d = 16'd0;
      end else if (wr_accept) begin
         cap_cnt_d = cap_cnt_inc;
      end
   end

   // FIFO pointers, occupancy and sticky overflow
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      if (clear_in) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         level_d    = '0;
         overflow_d = 1'b0;
      end else begin
         // Pointers are exactly ADDR_WIDTH bits so they wrap modulo DEPTH.
         if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         unique case ({wr_accept, rd_accept})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
         endcase
         if (wr_offered && !wr_accept) begin
            overflow_d = 1'b1;
         end
      end
   end

   // Read port and threshold interrupt
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = rd_accept;
      if (rd_accept) begin
         rd_data_d = mem_q[rd_ptr_q];
      end
      irq_d = (threshold_in != '0) && (level_q >= threshold_in);
   end

   // Control and status registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         cap_cnt_q  <= 16'd0;
         target_q   <= 16'd1;
         oneshot_q  <= 1'b0;
         overflow_q <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         cap_cnt_q  <= cap_cnt_d;
         target_q   <= target_d;
         oneshot_q  <= oneshot_d;
         overflow_q <= overflow_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         irq_q      <= irq_d;
      end
   end

   // Sample storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (rst && wr_accept) begin
         mem_q[wr_ptr_q] <= data_in;
      end
   end

   assign rd_data_out  = rd_data_q;
   assign rd_valid_out = rd_valid_q;
   assign level_out    = level_q;
   assign empty_out    = fifo_empty;
   assign full_out     = fifo_full;
   assign overflow_out = overflow_q;
   assign done_out     = (state_q == ST_DONE);
   assign busy_out     = (state_q == ST_RUN);
   assign irq_out      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adc_sample_fifo
//  Purpose  : Self-checking bench for adc_sample_fifo. Directed scenarios plus
//             a randomized run, all compared with a queue-based reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adc_sample_fifo;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] data_in = '0;
   logic        data_valid_in = 1'b0;
   logic        start_in = 1'b0;
   logic        stop_in = 1'b0;
   logic        oneshot_in = 1'b0;
   logic [15:0] count_in = '0;
   logic        clear_in = 1'b0;
   logic        rd_en_in = 1'b0;
   logic [4:0]  threshold_in = '0;
   logic [31:0] rd_data_out;
   logic        rd_valid_out;
   logic [4:0]  level_out;
   logic        empty_out, full_out, overflow_out, done_out, busy_out, irq_out;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   adc_sample_fifo #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_valid_in(data_valid_in),
      .start_in(start_in), .stop_in(stop_in), .oneshot_in(oneshot_in),
      .count_in(count_in), .clear_in(clear_in), .rd_en_in(rd_en_in),
      .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out),
      .threshold_in(threshold_in), .level_out(level_out), .empty_out(empty_out),
      .full_out(full_out), .overflow_out(overflow_out), .done_out(done_out),
      .busy_out(busy_out), .irq_out(irq_out)
   );

   // Reference model: stored samples as a queue, session as two flags.
   logic [31:0] m_q[$];
   bit          m_running = 0, m_done = 0, m_oneshot = 0;
   int          m_target = 1, m_cnt = 0;
   logic [31:0] m_rd_data = '0;
   bit          m_rd_valid = 0, m_ovf = 0, m_irq = 0;

   task automatic model_step();
      int lvl;
      bit rd_ok, offered, wr_ok;
      lvl = m_q.size();
      if (!rst) begin
         m_q.delete();
         m_running = 0; m_done = 0; m_rd_data = '0; m_rd_valid = 0;
         m_ovf = 0; m_irq = 0; m_cnt = 0;
         return;
      end
      m_irq   = (threshold_in != 0) && (lvl >= int'(threshold_in));
      rd_ok   = !clear_in && rd_en_in && (lvl != 0);
      offered = !clear_in && m_running && data_valid_in;
      wr_ok   = offered && ((lvl < DEPTH) || rd_ok);
      m_rd_valid = rd_ok;
      if (rd_ok) m_rd_data = m_q.pop_front();
      if (wr_ok) m_q.push_back(data_in);
      if (clear_in) begin
         m_q.delete(); m_ovf = 0; m_cnt = 0;
      end else if (offered && !wr_ok) begin
         m_ovf = 1;
      end
      if (wr_ok && m_cnt < 65535) m_cnt++;
      if (m_running) begin
         if (stop_in) m_running = 0;
         else if (m_oneshot && wr_ok && m_cnt == m_target) begin
            m_running = 0; m_done = 1;
         end
      end else if (m_done && clear_in) begin
         m_done = 0;
      end else if (start_in && !stop_in) begin
         m_running = 1; m_done = 0; m_oneshot = oneshot_in;
         m_target = (count_in == 0) ? 1 : int'(count_in);
         m_cnt = 0;
      end
   endtask

   // One clock: inputs set beforehand are sampled, model advances, pulses drop.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      start_in = 0; stop_in = 0; clear_in = 0; data_valid_in = 0; rd_en_in = 0;
   endtask

   task automatic test_reset();
      rst = 0; tick(); tick(); rst = 1;
      n_vec++; if (rd_data_out !== 32'h0) begin n_err++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data_out); end
      n_vec++; if (rd_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid_out); end
      n_vec++; if (level_out !== 5'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level_out); end
      n_vec++; if (empty_out !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", empty_out); end
      n_vec++; if (full_out !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", full_out); end
      n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b expected 0", overflow_out); end
      n_vec++; if (done_out !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done_out); end
      n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
      n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq_out); end
   endtask

   task automatic test_basic();
      oneshot_in = 0; start_in = 1; tick();
      n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b expected 1", busy_out); end
      for (int i = 0; i < 5; i++) begin
         data_in = 32'h11 + i; data_valid_in = 1; tick();
      end
      n_vec++; if (level_out !== 5'd5) begin n_err++; $display("FAIL basic_level5: got %0d expected 5", level_out); end
      for (int i = 0; i < 5; i++) begin
         rd_en_in = 1; tick();
         n_vec++; if (rd_valid_out !== 1'b1) begin n_err++; $display("FAIL basic_rd_valid: got %b expected 1", rd_valid_out); end
         n_vec++; if (rd_data_out !== 32'h11 + i) begin n_err++; $display("FAIL basic_rd_data: got %0h expected %0h", rd_data_out, 32'h11 + i); end
         tick();
         n_vec++; if (rd_valid_out !== 1'b0) begin n_err++; $display("FAIL basic_rd_pulse: got %b expected 0", rd_valid_out); end
      end
      n_vec++; if (level_out !== 5'd0) begin n_err++; $display("FAIL basic_level0: got %0d expected 0", level_out); end
      n_vec++; if (empty_out !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b expected 1", empty_out); end
      rd_en_in = 1; tick();
      n_vec++; if (rd_valid_out !== 1'b0) begin n_err++; $display("FAIL basic_rd_empty: got %b expected 0", rd_valid_out); end
      n_vec++; if (rd_data_out !== 32'h15) begin n_err++; $display("FAIL basic_rd_hold: got %0h expected 15", rd_data_out); end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 18; i++) begin
         data_in = i; data_valid_in = 1; tick();
      end
      n_vec++; if (level_out !== 5'd16) begin n_err++; $display("FAIL ovf_level: got %0d expected 16", level_out); end
      n_vec++; if (full_out !== 1'b1) begin n_err++; $display("FAIL ovf_full: got %b expected 1", full_out); end
      n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow_out); end
      for (int i = 1; i <= 16; i++) begin
         rd_en_in = 1; tick();
         n_vec++; if (rd_data_out !== 32'(i)) begin n_err++; $display("FAIL ovf_rd_data: got %0h expected %0h", rd_data_out, i); end
      end
      n_vec++; if (empty_out !== 1'b1) begin n_err++; $display("FAIL ovf_empty: got %b expected 1", empty_out); end
      n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow_out); end
      clear_in = 1; tick();
      n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b expected 0", overflow_out); end
      n_vec++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL ovf_clear_busy: got %b expected 1", busy_out); end
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 16; i++) begin
         data_in = 32'h100 + i; data_valid_in = 1; tick();
      end
      data_in = 32'hABC; data_valid_in = 1; rd_en_in = 1; tick();
      n_vec++; if (rd_valid_out !== 1'b1) begin n_err++; $display("FAIL frw_rd_valid: got %b expected 1", rd_valid_out); end
      n_vec++; if (rd_data_out !== 32'h100) begin n_err++; $display("FAIL frw_rd_data: got %0h expected 100", rd_data_out); end
      n_vec++; if (level_out !== 5'd16) begin n_err++; $display("FAIL frw_level: got %0d expected 16", level_out); end
      n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL frw_overflow: got %b expected 0", overflow_out); end
      for (int i = 1; i <= 16; i++) begin
         rd_en_in = 1; tick();
         n_vec++; if (rd_data_out !== ((i == 16) ? 32'hABC : 32'h100 + i)) begin n_err++; $display("FAIL frw_drain: got %0h at read %0d", rd_data_out, i); end
      end
      // Write and read together while empty: nothing comes back, level becomes 1.
      data_in = 32'h55; data_valid_in = 1; rd_en_in = 1; tick();
      n_vec++; if (rd_valid_out !== 1'b0) begin n_err++; $display("FAIL frw_no_fallthru: got %b expected 0", rd_valid_out); end
      n_vec++; if (level_out !== 5'd1) begin n_err++; $display("FAIL frw_ft_level: got %0d expected 1", level_out); end
      stop_in = 1; start_in = 1; tick();
      n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL frw_stop: got %b expected 0", busy_out); end
      clear_in = 1; tick();
   endtask

   task automatic test_oneshot();
      oneshot_in = 1; count_in = 16'd3; start_in = 1; tick();
      for (int i = 0; i < 6; i++) begin
         data_in = 32'h200 + i; data_valid_in = 1; tick();
         n_vec++; if (done_out !== (i >= 2)) begin n_err++; $display("FAIL os_done: got %b expected %b at strobe %0d", done_out, i >= 2, i); end
         n_vec++; if (busy_out !== (i < 2)) begin n_err++; $display("FAIL os_busy: got %b expected %b at strobe %0d", busy_out, i < 2, i); end
      end
      n_vec++; if (level_out !== 5'd3) begin n_err++; $display("FAIL os_level: got %0d expected 3", level_out); end
      n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL os_overflow: got %b expected 0", overflow_out); end
      for (int i = 0; i < 3; i++) begin
         rd_en_in = 1; tick();
         n_vec++; if (rd_data_out !== 32'h200 + i) begin n_err++; $display("FAIL os_rd_data: got %0h expected %0h", rd_data_out, 32'h200 + i); end
      end
      clear_in = 1; tick();
      n_vec++; if (done_out !== 1'b0) begin n_err++; $display("FAIL os_clear_done: got %b expected 0", done_out); end
      // A count of zero acts as one.
      count_in = 16'd0; start_in = 1; tick();
      data_in = 32'h300; data_valid_in = 1; tick();
      n_vec++; if (done_out !== 1'b1) begin n_err++; $display("FAIL os_count0_done: got %b expected 1", done_out); end
      data_in = 32'h301; data_valid_in = 1; tick();
      n_vec++; if (level_out !== 5'd1) begin n_err++; $display("FAIL os_count0_level: got %0d expected 1", level_out); end
      clear_in = 1; oneshot_in = 0; tick();
   endtask

   task automatic test_irq();
      threshold_in = 5'd4; oneshot_in = 0; start_in = 1; tick();
      for (int i = 0; i < 4; i++) begin
         data_in = i; data_valid_in = 1; tick();
         n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL irq_low: got %b expected 0 at write %0d", irq_out, i); end
      end
      tick();
      n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b expected 1", irq_out); end
      rd_en_in = 1; tick();
      n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b expected 1", irq_out); end
      tick();
      n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b expected 0", irq_out); end
      data_valid_in = 1; tick(); tick();
      n_vec++; if (irq_out !== 1'b1) begin n_err++; $display("FAIL irq_rerise: got %b expected 1", irq_out); end
      threshold_in = 5'd0; tick();
      n_vec++; if (irq_out !== 1'b0) begin n_err++; $display("FAIL irq_disable: got %b expected 0", irq_out); end
      clear_in = 1; tick();
   endtask

   task automatic test_reset_mid_run();
      for (int i = 0; i < 7; i++) begin
         data_in = 32'h400 + i; data_valid_in = 1; tick();
      end
      n_vec++; if (level_out !== 5'd7) begin n_err++; $display("FAIL rmr_level7: got %0d expected 7", level_out); end
      rst = 0; tick(); rst = 1;
      n_vec++; if (level_out !== 5'd0) begin n_err++; $display("FAIL rmr_level: got %0d expected 0", level_out); end
      n_vec++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rmr_busy: got %b expected 0", busy_out); end
      n_vec++; if (empty_out !== 1'b1) begin n_err++; $display("FAIL rmr_empty: got %b expected 1", empty_out); end
      n_vec++; if (rd_data_out !== 32'h0) begin n_err++; $display("FAIL rmr_rd_data: got %0h expected 0", rd_data_out); end
      for (int i = 0; i < 3; i++) begin
         data_valid_in = 1; tick();
      end
      n_vec++; if (level_out !== 5'd0) begin n_err++; $display("FAIL rmr_ignored: got %0d expected 0", level_out); end
      n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL rmr_no_ovf: got %b expected 0", overflow_out); end
      start_in = 1; tick();
      data_in = 32'h500; data_valid_in = 1; tick();
      n_vec++; if (level_out !== 5'd1) begin n_err++; $display("FAIL rmr_restart: got %0d expected 1", level_out); end
   endtask

   task automatic test_random();
      int rd_pct, wr_pct;
      rst = 0; tick(); rst = 1;
      for (int c = 0; c < 4000; c++) begin
         if (c % 250 == 0) begin
            rd_pct = $urandom_range(10, 90);
            wr_pct = $urandom_range(10, 90);
         end
         rst           = ($urandom_range(0, 399) != 0);
         start_in      = ($urandom_range(0, 29) == 0);
         stop_in       = ($urandom_range(0, 79) == 0);
         clear_in      = ($urandom_range(0, 99) == 0);
         oneshot_in    = $urandom_range(0, 1);
         count_in      = 16'($urandom_range(0, 20));
         data_valid_in = ($urandom_range(0, 99) < wr_pct);
         rd_en_in      = ($urandom_range(0, 99) < rd_pct);
         data_in       = $urandom;
         if ($urandom_range(0, 49) == 0) threshold_in = 5'($urandom_range(0, 16));
         tick();
         n_vec++; if (rd_valid_out !== m_rd_valid) begin n_err++; $display("FAIL rnd_rd_valid c%0d: got %b expected %b", c, rd_valid_out, m_rd_valid); end
         n_vec++; if (rd_data_out !== m_rd_data) begin n_err++; $display("FAIL rnd_rd_data c%0d: got %0h expected %0h", c, rd_data_out, m_rd_data); end
         n_vec++; if (int'(level_out) !== m_q.size()) begin n_err++; $display("FAIL rnd_level c%0d: got %0d expected %0d", c, level_out, m_q.size()); end
         n_vec++; if (empty_out !== (m_q.size() == 0)) begin n_err++; $display("FAIL rnd_empty c%0d: got %b", c, empty_out); end
         n_vec++; if (full_out !== (m_q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full c%0d: got %b", c, full_out); end
         n_vec++; if (overflow_out !== m_ovf) begin n_err++; $display("FAIL rnd_overflow c%0d: got %b expected %b", c, overflow_out, m_ovf); end
         n_vec++; if (done_out !== m_done) begin n_err++; $display("FAIL rnd_done c%0d: got %b expected %b", c, done_out, m_done); end
         n_vec++; if (busy_out !== m_running) begin n_err++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy_out, m_running); end
         n_vec++; if (irq_out !== m_irq) begin n_err++; $display("FAIL rnd_irq c%0d: got %b expected %b", c, irq_out, m_irq); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_rw();
      test_oneshot();
      test_irq();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
